vec3_length_seq: RTL and testbench
==================================

// Module: vec3_length_seq
// PURPOSE
//   Multi-cycle Q16.16 vector magnitude unit: accepts (x,y,z) over a valid/ready
//   handshake and returns |v| = sqrt(x^2+y^2+z^2) and |v|^2, both Q16.16.
//   It recovers the length that vec3_normalize divides out, so downstream
//   shading can rebuild v = |v| * n_hat.
//   It shares one 32x32 multiplier and uses a digit-serial square root,
//   trading latency for area on the ray datapath.
// PARAMETERS
//   BITS_PER_CYCLE  1  root bits resolved per ROOT cycle; legal 1,2,4;
//                      NR = 32/BITS_PER_CYCLE root cycles
// PORTS
//   clk        in   1   clock, all state on rising edge
//   rst        in   1   synchronous reset, active-high
//   in_valid   in   1   x/y/z valid
//   in_ready   out  1   unit can accept a vector
//   x,y,z      in   32  signed Q16.16 components
//   out_valid  out  1   mag/mag2/sat valid
//   out_ready  in   1   consumer takes the result
//   mag        out  32  signed Q16.16 magnitude, always >= 0
//   mag2       out  32  signed Q16.16 squared magnitude, always >= 0
//   sat        out  1   mag or mag2 clipped to 0x7FFFFFFF
// BEHAVIOUR
//   Reset
//   - Synchronous reset: state=IDLE, in_ready=1, out_valid=0, mag=mag2=0, sat=0.
//   - Reset wins over every other event, including mid-SQ/ROOT or in DONE.
//   States and transitions
//   - IDLE (in_ready=1): in_valid&&in_ready captures x,y,z, clears the 64-bit
//     accumulator S, then goes to SQ.
//   - SQ (3 cycles, idx 0..2): S += comp*comp, with the full 64-bit signed
//     product reinterpreted as unsigned (always >=0). Order is x, y, z.
//     S is raw Q32.32 and cannot exceed 3*2^62, so no overflow. Then ROOT.
//   - ROOT (NR cycles): non-restoring digit-by-digit integer sqrt of S, MSB
//     first, 34-bit remainder. R = floor(sqrt(S)), which is exactly Q16.16
//     |v| truncated. Then DONE.
//   - DONE (out_valid=1, in_ready=0): the outputs are registered on entry and
//     held stable until out_valid&&out_ready, which returns to IDLE.
//     in_valid is ignored outside IDLE.
//   Output arithmetic
//   - mag  = R[31] ? 32'h7FFFFFFF : R.
//   - mag2 = (S>>16) > 32'h7FFFFFFF ? 32'h7FFFFFFF : S[47:16] (truncate).
//   - sat  = either clip occurred.
//   - The sign of inputs is irrelevant, e.g. (-3,-4,0) equals (3,4,0).
//   Timing
//   - Latency: out_valid is high 3+NR cycles after the accepting edge
//     (35 cycles for BITS_PER_CYCLE=1).
//   - The earliest next accept is 2 edges after the first out_valid cycle if
//     out_ready is held high. The back-to-back period is 5+NR cycles.
//   - in_ready is purely a function of state (no combinational path from
//     out_ready). Outputs change only on the DONE-entry edge or reset.
// TESTING
//   - (3.0,4.0,0) = 0x00030000,0x00040000,0 -> mag=0x00050000,
//     mag2=0x00190000, sat=0. Repeat at BITS_PER_CYCLE=1,2,4 and check
//     latency 35/19/11.
//   - (0,0,0) -> mag=0, mag2=0, sat=0; (-1,-1,-1)*0x00010000 -> mag=0x0001BB67,
//     mag2=0x00030000.
//   - x=y=z=0x80000000 -> mag=0x7FFFFFFF, mag2=0x7FFFFFFF, sat=1; the next
//     vector (1 LSB,0,0) -> mag=0x00000001, mag2=0, sat=0.
//   - Hold out_ready=0 for 10 cycles in DONE -> mag/mag2/sat stable,
//     in_ready=0, and an in_valid pulse is ignored. Then out_ready=1 ->
//     IDLE next edge.
//   - Assert rst for 1 cycle midway through ROOT -> next cycle out_valid=0,
//     in_ready=1, outputs 0. A new (3,4,0) then yields 0x00050000 with
//     normal latency.
//   - 200 random vectors with random out_ready -> mag matches
//     floor(sqrt(x^2+y^2+z^2)) on a 64-bit model, with no dropped or
//     duplicated results.

Source files
------------

// File: rtl/vec3_length_seq.sv
// Q16.16 vector magnitude: |v| via one shared 32x32 squarer, then a digit-serial non-restoring sqrt.
// Latency 3+NR cycles from accept to out_valid (NR = 32/BITS_PER_CYCLE); one vector in flight at a time.
// in_ready is high only in IDLE; results are held in DONE until out_valid && out_ready.
module vec3_length_seq #(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] x,
    input  logic [31:0] y,
    input  logic [31:0] z,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] mag,
    output logic [31:0] mag2,
    output logic        sat
);

    localparam int         NR   = 32 / BITS_PER_CYCLE;
    localparam logic [4:0] LAST = 5'(NR - 1);

    typedef enum logic [1:0] {
        IDLE,
        SQ,
        ROOT,
        DONE
    } state_t;

    state_t      state;
    logic [31:0] xr;
    logic [31:0] yr;
    logic [31:0] zr;
    logic [1:0]  idx;
    logic [4:0]  cnt;
    logic [63:0] acc;
    logic [63:0] rad;
    logic [33:0] rem;
    logic [31:0] root;

    logic signed [31:0] comp;
    logic signed [63:0] comp_w;
    logic signed [63:0] prod;
    logic [63:0]        acc_n;
    logic [33:0]        rem_n;
    logic [31:0]        root_n;
    logic [63:0]        rad_n;
    logic               mag_clip;
    logic               mag2_clip;

    // Shared squarer: the component is picked by idx, the signed square is always >= 0.
    always_comb begin
        comp = zr;
        unique case (idx)
            2'd0:    comp = xr;
            2'd1:    comp = yr;
            default: comp = zr;
        endcase
        comp_w = 64'(comp);
        prod   = comp_w * comp_w;
        acc_n  = acc + $unsigned(prod);
    end

    // Non-restoring sqrt digits: the remainder sign picks subtract (r>=0) or add (r<0).
    always_comb begin
        rem_n  = rem;
        root_n = root;
        rad_n  = rad;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (!rem_n[33]) begin
                rem_n = {rem_n[31:0], rad_n[63:62]} - {root_n, 2'b01};
            end else begin
                rem_n = {rem_n[31:0], rad_n[63:62]} + {root_n, 2'b11};
            end
            root_n = {root_n[30:0], ~rem_n[33]};
            rad_n  = {rad_n[61:0], 2'b00};
        end
    end

    assign mag_clip  = root_n[31];
    assign mag2_clip = |acc[63:47];

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            mag       <= '0;
            mag2      <= '0;
            sat       <= 1'b0;
            xr        <= '0;
            yr        <= '0;
            zr        <= '0;
            idx       <= '0;
            cnt       <= '0;
            acc       <= '0;
            rad       <= '0;
            rem       <= '0;
            root      <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        xr       <= x;
                        yr       <= y;
                        zr       <= z;
                        acc      <= '0;
                        idx      <= '0;
                        in_ready <= 1'b0;
                        state    <= SQ;
                    end
                end
                SQ: begin
                    acc <= acc_n;
                    idx <= idx + 2'd1;
                    if (idx == 2'd2) begin
                        rad   <= acc_n;
                        rem   <= '0;
                        root  <= '0;
                        cnt   <= '0;
                        state <= ROOT;
                    end
                end
                ROOT: begin
                    rem  <= rem_n;
                    root <= root_n;
                    rad  <= rad_n;
                    cnt  <= cnt + 5'd1;
                    // Outputs are taken from the final digit step so they land on the DONE-entry edge.
                    if (cnt == LAST) begin
                        mag       <= mag_clip  ? 32'h7FFF_FFFF : root_n;
                        mag2      <= mag2_clip ? 32'h7FFF_FFFF : acc[47:16];
                        sat       <= mag_clip | mag2_clip;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vec3_length_seq.sv
// Bench for vec3_length_seq: directed corner cases, latency at three digit widths, random scoreboard.
module tb_vec3_length_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] z;

    logic        in_ready, out_valid, sat;
    logic [31:0] mag, mag2;
    logic        in_ready_2, out_valid_2, sat_2;
    logic [31:0] mag_2, mag2_2;
    logic        in_ready_4, out_valid_4, sat_4;
    logic [31:0] mag_4, mag2_4;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    vec3_length_seq #(.BITS_PER_CYCLE(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .y(y), .z(z), .out_valid(out_valid), .out_ready(out_ready),
        .mag(mag), .mag2(mag2), .sat(sat)
    );

    vec3_length_seq #(.BITS_PER_CYCLE(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_2),
        .x(x), .y(y), .z(z), .out_valid(out_valid_2), .out_ready(out_ready),
        .mag(mag_2), .mag2(mag2_2), .sat(sat_2)
    );

    vec3_length_seq #(.BITS_PER_CYCLE(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_4),
        .x(x), .y(y), .z(z), .out_valid(out_valid_4), .out_ready(out_ready),
        .mag(mag_4), .mag2(mag2_4), .sat(sat_4)
    );

    // Reference: exact sum of squares in 64 bits, floor sqrt by bitwise search, then clipping.
    function automatic void model(input logic [31:0] vx, input logic [31:0] vy, input logic [31:0] vz,
                                  output logic [31:0] em, output logic [31:0] em2, output logic es);
        longint      a, b, c;
        logic [63:0] s, r, cand;
        a = longint'(signed'(vx));
        b = longint'(signed'(vy));
        c = longint'(signed'(vz));
        s = $unsigned(a * a) + $unsigned(b * b) + $unsigned(c * c);
        r = 64'd0;
        for (int k = 31; k >= 0; k--) begin
            cand = r | (64'd1 << k);
            if (cand * cand <= s) r = cand;
        end
        em  = (r > 64'h7FFF_FFFF) ? 32'h7FFF_FFFF : r[31:0];
        em2 = ((s >> 16) > 64'h7FFF_FFFF) ? 32'h7FFF_FFFF : s[47:16];
        es  = (r > 64'h7FFF_FFFF) || ((s >> 16) > 64'h7FFF_FFFF);
    endfunction

    function automatic logic [31:0] rnd();
        logic [31:0] v;
        v = $urandom;
        case ($urandom_range(0, 3))
            0:       return v;
            1:       return 32'($signed(v) >>> 16);
            2:       return 32'($signed(v) >>> 8);
            default: return 32'($signed(v) >>> 20);
        endcase
    endfunction

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        x = '0; y = '0; z = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Returns one time unit after the accepting edge.
    task automatic send(input logic [31:0] vx, input logic [31:0] vy, input logic [31:0] vz, output bit ok);
        int t;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            n_cmp++; n_bad++;
            $display("FAIL send: in_ready=%b after %0d cycles, want 1", in_ready, t);
            ok = 1'b0;
            return;
        end
        x = vx; y = vy; z = vz;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        ok = 1'b1;
    endtask

    task automatic wait_out(output int lat);
        lat = -1;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = c;
                break;
            end
        end
        if (lat < 0) begin
            n_cmp++; n_bad++;
            $display("FAIL wait_out: out_valid=0 after 200 cycles, want 1");
        end
    endtask

    task automatic run_one(input logic [31:0] vx, input logic [31:0] vy, input logic [31:0] vz, output int lat);
        bit ok;
        out_ready = 1'b0;
        lat = -1;
        send(vx, vy, vz, ok);
        if (ok) wait_out(lat);
    endtask

    task automatic release_out();
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (in_ready !== 1'b1)  begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (mag !== 32'h0)      begin n_bad++; $display("FAIL reset_mag: got %h want 0", mag); end
        n_cmp++; if (mag2 !== 32'h0)     begin n_bad++; $display("FAIL reset_mag2: got %h want 0", mag2); end
        n_cmp++; if (sat !== 1'b0)       begin n_bad++; $display("FAIL reset_sat: got %b want 0", sat); end
        n_cmp++; if ({in_ready_2, in_ready_4} !== 2'b11) begin n_bad++; $display("FAIL reset_in_ready_24: got %b want 11", {in_ready_2, in_ready_4}); end
    endtask

    task automatic test_latency_bpc();
        int  l1, l2, l4;
        bit  ok;
        l1 = -1; l2 = -1; l4 = -1;
        do_reset();
        send(32'h0003_0000, 32'h0004_0000, 32'h0, ok);
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk);
            #1;
            if (out_valid   && l1 < 0) l1 = c;
            if (out_valid_2 && l2 < 0) l2 = c;
            if (out_valid_4 && l4 < 0) l4 = c;
        end
        n_cmp++; if (l1 != 35) begin n_bad++; $display("FAIL latency_bpc1: got %0d want 35", l1); end
        n_cmp++; if (l2 != 19) begin n_bad++; $display("FAIL latency_bpc2: got %0d want 19", l2); end
        n_cmp++; if (l4 != 11) begin n_bad++; $display("FAIL latency_bpc4: got %0d want 11", l4); end
        n_cmp++; if ({mag, mag2, sat} !== {32'h0005_0000, 32'h0019_0000, 1'b0})
            begin n_bad++; $display("FAIL bpc1_345: got %h %h %b want 00050000 00190000 0", mag, mag2, sat); end
        n_cmp++; if ({mag_2, mag2_2, sat_2} !== {32'h0005_0000, 32'h0019_0000, 1'b0})
            begin n_bad++; $display("FAIL bpc2_345: got %h %h %b want 00050000 00190000 0", mag_2, mag2_2, sat_2); end
        n_cmp++; if ({mag_4, mag2_4, sat_4} !== {32'h0005_0000, 32'h0019_0000, 1'b0})
            begin n_bad++; $display("FAIL bpc4_345: got %h %h %b want 00050000 00190000 0", mag_4, mag2_4, sat_4); end
        release_out();
    endtask

    task automatic test_zero_neg();
        int lat;
        run_one(32'h0, 32'h0, 32'h0, lat);
        n_cmp++; if ({mag, mag2, sat} !== {32'h0, 32'h0, 1'b0})
            begin n_bad++; $display("FAIL zero_vec: got %h %h %b want 0 0 0", mag, mag2, sat); end
        release_out();
        run_one(32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000, lat);
        n_cmp++; if ({mag, mag2, sat} !== {32'h0001_BB67, 32'h0003_0000, 1'b0})
            begin n_bad++; $display("FAIL neg_ones: got %h %h %b want 0001bb67 00030000 0", mag, mag2, sat); end
        release_out();
        run_one(32'hFFFD_0000, 32'hFFFC_0000, 32'h0, lat);
        n_cmp++; if ({mag, mag2, sat} !== {32'h0005_0000, 32'h0019_0000, 1'b0})
            begin n_bad++; $display("FAIL neg_345: got %h %h %b want 00050000 00190000 0", mag, mag2, sat); end
        release_out();
    endtask

    task automatic test_saturation();
        int lat;
        run_one(32'h8000_0000, 32'h8000_0000, 32'h8000_0000, lat);
        n_cmp++; if ({mag, mag2, sat} !== {32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1})
            begin n_bad++; $display("FAIL sat_max: got %h %h %b want 7fffffff 7fffffff 1", mag, mag2, sat); end
        release_out();
        run_one(32'h1, 32'h0, 32'h0, lat);
        n_cmp++; if ({mag, mag2, sat} !== {32'h1, 32'h0, 1'b0})
            begin n_bad++; $display("FAIL one_lsb: got %h %h %b want 00000001 00000000 0", mag, mag2, sat); end
        release_out();
    endtask

    task automatic test_hold();
        int lat;
        run_one(32'h0003_0000, 32'h0004_0000, 32'h0, lat);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            in_valid = (c == 4);
            x = 32'h0001_0000; y = 32'h0; z = 32'h0;
            @(posedge clk);
            #1;
            n_cmp++; if ({mag, mag2, sat} !== {32'h0005_0000, 32'h0019_0000, 1'b0})
                begin n_bad++; $display("FAIL hold_data c=%0d: got %h %h %b want 00050000 00190000 0", c, mag, mag2, sat); end
            n_cmp++; if ({out_valid, in_ready} !== 2'b10)
                begin n_bad++; $display("FAIL hold_flags c=%0d: got valid/ready %b want 10", c, {out_valid, in_ready}); end
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++; if ({out_valid, in_ready} !== 2'b01)
            begin n_bad++; $display("FAIL hold_release: got valid/ready %b want 01", {out_valid, in_ready}); end
        @(negedge clk);
        out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        n_cmp++; if ({out_valid, in_ready} !== 2'b01)
            begin n_bad++; $display("FAIL hold_pulse_ignored: got valid/ready %b want 01", {out_valid, in_ready}); end
    endtask

    task automatic test_reset_mid_root();
        int lat;
        bit ok;
        out_ready = 1'b0;
        send(32'h0001_0000, 32'h0002_0000, 32'h0002_0000, ok);
        repeat (13) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++; if ({out_valid, in_ready} !== 2'b01)
            begin n_bad++; $display("FAIL midroot_flags: got valid/ready %b want 01", {out_valid, in_ready}); end
        n_cmp++; if ({mag, mag2, sat} !== {32'h0, 32'h0, 1'b0})
            begin n_bad++; $display("FAIL midroot_outputs: got %h %h %b want 0 0 0", mag, mag2, sat); end
        @(negedge clk);
        rst = 1'b0;
        run_one(32'h0003_0000, 32'h0004_0000, 32'h0, lat);
        n_cmp++; if (lat != 35) begin n_bad++; $display("FAIL midroot_latency: got %0d want 35", lat); end
        n_cmp++; if (mag !== 32'h0005_0000) begin n_bad++; $display("FAIL midroot_mag: got %h want 00050000", mag); end
        release_out();
    endtask

    task automatic test_random();
        logic [64:0] q[$];
        logic [64:0] e;
        logic [31:0] em, em2;
        logic        es;
        int          sent, recv, cyc;
        sent = 0; recv = 0; cyc = 0;
        while (recv < 200 && cyc < 30000) begin
            @(negedge clk);
            cyc++;
            in_valid  = (sent < 200) && ($urandom_range(0, 3) != 0);
            x = rnd(); y = rnd(); z = rnd();
            out_ready = ($urandom_range(0, 1) == 1);
            // Outputs are registered, so what is visible now is what the next edge hands over.
            if (out_valid && out_ready) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_bad++;
                    $display("FAIL rand_dup #%0d: got %h %h %b with no vector outstanding", recv, mag, mag2, sat);
                end else begin
                    e = q.pop_front();
                    if ({mag, mag2, sat} !== e) begin
                        n_bad++;
                        $display("FAIL rand_result #%0d: got %h %h %b want %h %h %b",
                                 recv, mag, mag2, sat, e[64:33], e[32:1], e[0]);
                    end
                end
                recv++;
            end
            if (in_valid && in_ready) begin
                model(x, y, z, em, em2, es);
                q.push_back({em, em2, es});
                sent++;
            end
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        n_cmp++; if (recv != 200) begin n_bad++; $display("FAIL rand_count: got %0d results want 200", recv); end
        n_cmp++; if (q.size() != 0) begin n_bad++; $display("FAIL rand_leftover: got %0d pending want 0", q.size()); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, %0d compared / %0d mismatched so far", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_latency_bpc();
        test_zero_neg();
        test_saturation();
        test_hold();
        test_reset_mid_root();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
